// File: rtl/fmap_buffer.sv
// Feature-map capture/replay buffer: stores one SIZE x SIZE frame from the conv
// output stream and replays it on request as a gap-free valid/end pixel stream.
//
//   state  | meaning
//   -------+------------------------------------------------------------
//   S_FILL | accepting pixels, writing at wr_cnt until the frame is complete
//   S_FULL | frame stored, waiting for start
//   S_READ | issuing one read per ce cycle at rd_cnt, then back to S_FILL
module fmap_buffer #(
    parameter int N       = 16,
    parameter int CHANNEL = 3,
    parameter int SIZE    = 6
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ce,
    input  logic                 input_vld,
    input  logic [CHANNEL*N-1:0] input_din,
    input  logic                 input_end,
    input  logic                 start,
    output logic [CHANNEL*N-1:0] dout,
    output logic                 dout_vld,
    output logic                 dout_end,
    output logic                 full,
    output logic                 busy,
    output logic                 err_overflow,
    output logic                 err_length
);
    localparam int DEPTH = SIZE * SIZE;
    localparam int AW    = $clog2(DEPTH);
    localparam int W     = CHANNEL * N;
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    typedef enum logic [1:0] {S_FILL, S_FULL, S_READ} state_t;

    state_t          state, state_nxt;
    logic [AW-1:0]   wr_cnt, wr_cnt_nxt;
    logic [AW-1:0]   rd_cnt, rd_cnt_nxt;
    logic            we, re, ovf_hit, len_hit;
    logic [W-1:0]    mem [DEPTH];

    always_comb begin
        state_nxt  = state;
        wr_cnt_nxt = wr_cnt;
        rd_cnt_nxt = rd_cnt;
        we         = 1'b0;
        re         = 1'b0;
        ovf_hit    = 1'b0;
        len_hit    = 1'b0;
        case (state)
            S_FILL: begin
                if (input_vld) begin
                    we = 1'b1;
                    // frame length comes from the count; input_end is only cross-checked
                    len_hit = (input_end != (wr_cnt == LAST));
                    if (wr_cnt == LAST) begin
                        wr_cnt_nxt = '0;
                        state_nxt  = S_FULL;
                    end else begin
                        wr_cnt_nxt = wr_cnt + 1'b1;
                    end
                end
            end
            S_FULL: begin
                ovf_hit = input_vld;
                if (start) begin
                    rd_cnt_nxt = '0;
                    state_nxt  = S_READ;
                end
            end
            S_READ: begin
                ovf_hit = input_vld;
                re      = 1'b1;
                if (rd_cnt == LAST) begin
                    rd_cnt_nxt = '0;
                    state_nxt  = S_FILL;
                end else begin
                    rd_cnt_nxt = rd_cnt + 1'b1;
                end
            end
            default: state_nxt = S_FILL;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_FILL;
            wr_cnt       <= '0;
            rd_cnt       <= '0;
            err_overflow <= 1'b0;
            err_length   <= 1'b0;
        end else if (ce) begin
            state        <= state_nxt;
            wr_cnt       <= wr_cnt_nxt;
            rd_cnt       <= rd_cnt_nxt;
            err_overflow <= err_overflow | ovf_hit;
            err_length   <= err_length | len_hit;
        end
    end

    // Storage is intentionally not reset; a stale frame is never replayed
    // because a reset forces a fresh fill before the next start is honoured.
    always_ff @(posedge clk) begin
        if (ce && we) begin
            mem[wr_cnt] <= input_din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout     <= '0;
            dout_vld <= 1'b0;
            dout_end <= 1'b0;
        end else if (ce) begin
            dout_vld <= re;
            dout_end <= re && (rd_cnt == LAST);
            if (re) begin
                dout <= mem[rd_cnt];
            end
        end
    end

    assign full = (state == S_FULL);
    assign busy = (state == S_READ);

endmodule

// File: tb/tb_fmap_buffer.sv
// Directed bench for fmap_buffer: table-driven replay-start window plus
// hand-written fill/replay/error/reset sequences against a pixel-value model.
module tb_fmap_buffer;
    localparam int N = 16;
    localparam int CHANNEL = 3;
    localparam int SIZE = 6;
    localparam int DEPTH = SIZE * SIZE;
    localparam int W = CHANNEL * N;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         ce = 1'b0;
    logic         input_vld = 1'b0;
    logic [W-1:0] input_din = '0;
    logic         input_end = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] dout;
    logic         dout_vld, dout_end, full, busy, err_overflow, err_length;

    int errors = 0;
    int checks = 0;

    fmap_buffer #(.N(N), .CHANNEL(CHANNEL), .SIZE(SIZE)) dut (
        .clk(clk), .rst_n(rst_n), .ce(ce),
        .input_vld(input_vld), .input_din(input_din), .input_end(input_end),
        .start(start), .dout(dout), .dout_vld(dout_vld), .dout_end(dout_end),
        .full(full), .busy(busy), .err_overflow(err_overflow), .err_length(err_length)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic ce;
        logic start;
        logic vld;
        logic exp_full;
        logic exp_busy;
        logic exp_vld;
        logic exp_end;
        int   exp_pix;
    } vec_t;

    function automatic logic [W-1:0] pix(int base, int k);
        return {16'(base + k + 200), 16'(base + k + 100), 16'(base + k)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(string name, logic act, logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chkw(string name, logic [W-1:0] act, logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chki(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic idle();
        ce = 1'b1;
        input_vld = 1'b0;
        input_end = 1'b0;
        start = 1'b0;
        input_din = '0;
    endtask

    task automatic chk_all_zero(string tag);
        chkw({tag, "_dout"}, dout, '0);
        chk1({tag, "_vld"}, dout_vld, 1'b0);
        chk1({tag, "_end"}, dout_end, 1'b0);
        chk1({tag, "_full"}, full, 1'b0);
        chk1({tag, "_busy"}, busy, 1'b0);
        chk1({tag, "_ovf"}, err_overflow, 1'b0);
        chk1({tag, "_len"}, err_length, 1'b0);
    endtask

    task automatic fill(int base, bit ce_rand, int end_at, bit start_noise, bit start_last);
        int  wr = 0;
        int  ticks = 0;
        bit  wrote;
        while (wr < DEPTH && ticks < 2000) begin
            ce        = ce_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            input_vld = ($urandom_range(0, 2) != 0);
            input_din = pix(base, wr);
            input_end = (wr == end_at);
            start     = start_noise ? 1'($urandom_range(0, 1)) : 1'b0;
            if (wr == DEPTH - 1 && input_vld) start = start_last;
            wrote = ce && input_vld;
            tick();
            ticks++;
            if (wrote) wr++;
            if (wrote && wr < DEPTH) chk1("full_early", full, 1'b0);
        end
        idle();
        chki("fill_count", wr, DEPTH);
        chk1("fill_full", full, 1'b1);
        chk1("fill_busy", busy, 1'b0);
    endtask

    task automatic do_start(bit ce_rand);
        int  ticks = 0;
        bit  done = 0;
        while (!done && ticks < 200) begin
            ce    = ce_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            start = 1'b1;
            done  = ce;
            tick();
            ticks++;
        end
        idle();
        chk1("start_taken", done, 1'b1);
        chk1("start_busy", busy, 1'b1);
        chk1("start_full", full, 1'b0);
    endtask

    // Collects replay words from index first; ovf_at injects input_vld, abort_at stops early.
    task automatic collect(int base, int first, bit ce_rand, int ovf_at, int abort_at);
        int           cnt = first;
        int           ticks = 0;
        bit           was_ce;
        bit           aborted = 0;
        logic [W-1:0] prev;
        while (cnt < DEPTH && ticks < 800 && !aborted) begin
            ce        = ce_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            input_vld = (ovf_at >= 0 && cnt == ovf_at);
            input_din = '1;
            input_end = input_vld;
            prev      = dout;
            was_ce    = ce;
            tick();
            ticks++;
            if (was_ce) begin
                chk1("rep_vld", dout_vld, 1'b1);
                chkw("rep_dout", dout, pix(base, cnt));
                chk1("rep_end", dout_end, cnt == DEPTH - 1);
                chk1("rep_busy", busy, cnt != DEPTH - 1);
                if (cnt == abort_at) aborted = 1;
                cnt++;
            end else begin
                chkw("hold_dout", dout, prev);
            end
        end
        idle();
        if (abort_at < 0) begin
            chki("rep_count", cnt, DEPTH);
            if (!ce_rand) chki("rep_consecutive", ticks, DEPTH - first);
            tick();
            chk1("post_vld", dout_vld, 1'b0);
            chk1("post_end", dout_end, 1'b0);
            chk1("post_busy", busy, 1'b0);
            chk1("post_full", full, 1'b0);
        end else begin
            chk1("abort_reached", aborted, 1'b1);
        end
    endtask

    vec_t vecs[7];

    initial begin
        // Replay-start window from FULL holding frame base 0.
        vecs[0] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, -1};
        vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, -1};
        vecs[2] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, -1};
        vecs[3] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 0};
        vecs[4] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 0};
        vecs[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1};
        vecs[6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2};

        idle();
        tick();
        tick();
        chk_all_zero("reset");
        #3 rst_n = 1'b1;
        tick();
        chk_all_zero("after_reset");

        // Clean fill with vld gaps, then table-driven start and in-order replay.
        fill(0, 1'b0, DEPTH - 1, 1'b0, 1'b0);
        chk1("f0_ovf", err_overflow, 1'b0);
        chk1("f0_len", err_length, 1'b0);
        for (int i = 0; i < 7; i++) begin
            ce        = vecs[i].ce;
            start     = vecs[i].start;
            input_vld = vecs[i].vld;
            input_din = '1;
            tick();
            chk1("tbl_full", full, vecs[i].exp_full);
            chk1("tbl_busy", busy, vecs[i].exp_busy);
            chk1("tbl_vld", dout_vld, vecs[i].exp_vld);
            chk1("tbl_end", dout_end, vecs[i].exp_end);
            chk1("tbl_ovf", err_overflow, 1'b0);
            if (vecs[i].exp_pix >= 0) chkw("tbl_dout", dout, pix(0, vecs[i].exp_pix));
        end
        idle();
        collect(0, 3, 1'b0, -1, -1);

        // Random ce during fill and replay.
        fill(1000, 1'b1, DEPTH - 1, 1'b0, 1'b0);
        do_start(1'b1);
        collect(1000, 0, 1'b1, -1, -1);
        chk1("f1_ovf", err_overflow, 1'b0);
        chk1("f1_len", err_length, 1'b0);

        // start during FILL and on the last write is ignored; overflow in FULL and READ.
        fill(2000, 1'b0, DEPTH - 1, 1'b1, 1'b1);
        tick();
        chk1("nostart_full", full, 1'b1);
        chk1("nostart_busy", busy, 1'b0);
        chk1("nostart_vld", dout_vld, 1'b0);
        chk1("pre_ovf", err_overflow, 1'b0);
        input_vld = 1'b1;
        input_din = '1;
        tick();
        idle();
        chk1("ovf_full", err_overflow, 1'b1);
        chk1("ovf_still_full", full, 1'b1);
        do_start(1'b0);
        collect(2000, 0, 1'b0, 5, -1);
        chk1("ovf_sticky", err_overflow, 1'b1);
        chk1("f2_len", err_length, 1'b0);

        // Early input_end, then reset in the middle of replay.
        fill(3000, 1'b0, 20, 1'b0, 1'b0);
        chk1("len_err", err_length, 1'b1);
        do_start(1'b0);
        collect(3000, 0, 1'b0, -1, 10);
        rst_n = 1'b0;
        #1;
        chk_all_zero("async_rst");
        #2 rst_n = 1'b1;
        tick();
        chk_all_zero("post_rst");

        fill(4000, 1'b0, DEPTH - 1, 1'b0, 1'b0);
        do_start(1'b0);
        collect(4000, 0, 1'b0, -1, -1);
        chk1("f4_ovf", err_overflow, 1'b0);
        chk1("f4_len", err_length, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fmap_buffer.md
# fmap_buffer

Feature-map capture/replay buffer sitting at the receiving end of a convolution output stream (`conv_dout` / `conv_dout_vld` / `conv_dout_end`). It stores one complete SIZE×SIZE frame of CHANNEL-wide pixels in internal memory. On request, it replays that frame as a pixel stream with the same valid/end framing, so the next layer or the host reader can consume it at full rate independent of the producer's gaps.

## Interface
- `N`, 16, bits per channel value (signed fixed-point, passed through untouched)
- `CHANNEL`, 3, channels packed per pixel word
- `SIZE`, 6, frame width = height; frame holds SIZE*SIZE pixels
- `clk`  in  1  clock; one clock domain
- `rst_n`  in  1  reset, asynchronous, active-low
- `ce`  in  1  global clock enable; when low, every register holds
- `input_vld`  in  1  qualifies `input_din` (one pixel per cycle with `ce`=1)
- `input_din`  in  CHANNEL*N  pixel word; channel c in bits [c*N +: N]
- `input_end`  in  1  producer's last-pixel marker; valid only with `input_vld`
- `start`  in  1  replay request, single-cycle pulse
- `dout`  out  CHANNEL*N  replayed pixel word (registered)
- `dout_vld`  out  1  qualifies `dout`
- `dout_end`  out  1  high with the last replayed pixel
- `full`  out  1  frame stored, waiting for `start`
- `busy`  out  1  replay in progress
- `err_overflow`  out  1  sticky: `input_vld` arrived while not in FILL
- `err_length`  out  1  sticky: `input_end` disagreed with pixel count

## Operation
- Memory: SIZE*SIZE words × CHANNEL*N bits, 1 write port, 1 registered read port; contents not reset.
- The state machine has three states:
  - FILL (reset state). Each `ce`&`input_vld` writes `input_din` at `wr_cnt`, then `wr_cnt`++. When the write at `wr_cnt`=SIZE*SIZE-1 happens, `wr_cnt` returns to 0 and the state moves to FULL.
  - FULL. `full`=1. `start`&`ce` moves the state to READ, with `rd_cnt`=0.
  - READ. `busy`=1. Each `ce` cycle issues a read at `rd_cnt`, then `rd_cnt`++. After the read at SIZE*SIZE-1 is issued, the state moves to FILL.
- Frame length is set by the count only, never by `input_end`. `err_length` is set if either of these occurs:
  - `input_end`=1 on a write with `wr_cnt`≠SIZE*SIZE-1;
  - `input_end`=0 on the write with `wr_cnt`=SIZE*SIZE-1.
- `input_vld` in FULL or READ: the pixel is dropped, memory and counters are unchanged, and `err_overflow` is set.
- `start` in FILL or READ: ignored, with no error.
- Last write and `start` in the same cycle: `start` is ignored (the state is still FILL at that edge).
- Error flags clear only on reset.
- No arithmetic is performed. Counters are $clog2(SIZE*SIZE) bits wide and wrap explicitly at SIZE*SIZE-1, never by overflow.

## Timing
- Reset values: `dout`=0, `dout_vld`=0, `dout_end`=0, `full`=0, `busy`=0, both error flags 0; state FILL, counters 0.
- `ce`=0 freezes state, counters, memory writes and all outputs, which keep their current values.
- Write: `input_din` is sampled at edge t. The first replay can read the stored pixel.
- Replay latency: `start` sampled at edge t, so `busy`=1 and `full`=0 after t. Address 0 is read at edge t+1, so `dout_vld`=1 with pixel 0 after t+1 (counting `ce`-high edges only).
- With `ce` held high, `dout_vld` stays high for exactly SIZE*SIZE consecutive cycles. `dout_end` is high only in the last of them.
- `busy` falls on the edge after which `dout_end` is high (read issue finished), and the state is FILL from that edge. A new `input_vld` in the `dout_end` cycle is therefore accepted.
- Reset mid-replay: outputs drop to 0 immediately, and a stored frame is discarded (`full`=0, FILL).

## Test plan
All scenarios use defaults: 36 pixels per frame, 48-bit words.
- Fill with pixels `{k,k+100,k+200}` for k=0..35, `input_end` on k=35, `ce`=1 with random `input_vld` gaps -> `full`=1 after the 36th write, no errors.
- `start` pulse after fill -> `dout_vld` 2 cycles later, 36 consecutive words equal to the written values in order, `dout_end` only on word 35, `busy` falls, then `full`=0.
- Toggle `ce` 50% randomly during fill and replay -> identical data and order, no duplicated or skipped pixel, outputs held while `ce`=0.
- `input_vld` during FULL and during READ -> `err_overflow`=1, replayed data unchanged. `input_end` on pixel 20 -> `err_length`=1 while the frame still completes at 36.
- `start` during FILL, and `start` coincident with the 36th write -> no replay, `full`=1. A later `start` replays normally.
- Assert `rst_n`=0 at replay word 10 -> all outputs 0 asynchronously. A fresh fill plus `start` afterwards gives a correct 36-word replay.
